parking_controller: RTL and testbench

//  Sequential controller for the 8-slot car park: owns the occupancy bitmap (parking_capacity

---
 rtl/parking_controller_pkg.sv | 14 +
 rtl/parking_controller_slot_finder.sv | 25 ++
 rtl/parking_controller.sv | 147 ++++++++++++++
 tb/tb_parking_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/parking_controller_pkg.sv
// Shared defaults and FSM state encoding for the car-park entry/exit controller.
package parking_controller_pkg;

  localparam int DEF_NUM_SLOTS    = 8;
  localparam int DEF_SLOT_W       = 3;
  localparam int DEF_GATE_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_OPEN  = 2'd2
  } state_t;

endpackage

// File: rtl/parking_controller_slot_finder.sv
// Lowest-zero priority encoder over the occupancy bitmap.
module parking_controller_slot_finder
  import parking_controller_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int SLOT_W    = DEF_SLOT_W
) (
  input  logic [NUM_SLOTS-1:0] bitmap,
  output logic                 found,
  output logic [SLOT_W-1:0]    index
);

  // Scanning from the top lets the lowest free slot overwrite any higher one.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!bitmap[i]) begin
        found = 1'b1;
        index = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/parking_controller.sv
// Car-park entry/exit controller: owns the occupancy bitmap, grants the lowest free slot,
// runs the entry gate with a reservation timeout and frees slots on exit.
//
//   state    | meaning
//   ST_IDLE  | gate closed, waiting for entry_req
//   ST_GRANT | slot reserved, park_number valid, gate opens on leaving
//   ST_OPEN  | gate open, waiting for car_passed or timeout
module parking_controller
  import parking_controller_pkg::*;
#(
  parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int SLOT_W       = DEF_SLOT_W,
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_req,
  input  logic                 car_passed,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic [NUM_SLOTS-1:0] parking_capacity,
  output logic [SLOT_W-1:0]    park_number,
  output logic                 park_valid,
  output logic                 gate_open,
  output logic                 full,
  output logic [SLOT_W:0]      free_count,
  output logic                 entry_reject,
  output logic                 exit_err
);

  localparam int TIMER_W = $clog2(GATE_TIMEOUT + 1);

  state_t               state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [NUM_SLOTS-1:0] cap_set, cap_clr, cap_n;
  logic [SLOT_W-1:0]    park_number_n;
  logic                 park_valid_n, gate_open_n;
  logic                 entry_reject_n, exit_err_n;
  logic [SLOT_W:0]      free_n;
  logic                 exit_ok;
  logic                 free_found;
  logic [SLOT_W-1:0]    free_idx;

  parking_controller_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_slot_finder (
    .bitmap (parking_capacity),
    .found  (free_found),
    .index  (free_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      timer            <= '0;
      parking_capacity <= '0;
      park_number      <= '0;
      park_valid       <= 1'b0;
      gate_open        <= 1'b0;
      full             <= 1'b0;
      free_count       <= (SLOT_W + 1)'(NUM_SLOTS);
      entry_reject     <= 1'b0;
      exit_err         <= 1'b0;
    end else begin
      state            <= state_n;
      timer            <= timer_n;
      parking_capacity <= cap_n;
      park_number      <= park_number_n;
      park_valid       <= park_valid_n;
      gate_open        <= gate_open_n;
      full             <= (free_n == '0);
      free_count       <= free_n;
      entry_reject     <= entry_reject_n;
      exit_err         <= exit_err_n;
    end
  end

  always_comb begin
    state_n        = state;
    timer_n        = timer;
    cap_set        = '0;
    cap_clr        = '0;
    park_number_n  = park_number;
    park_valid_n   = park_valid;
    gate_open_n    = gate_open;
    entry_reject_n = 1'b0;
    exit_err_n     = 1'b0;

    // The slot held by an entering car cannot be vacated until the car is parked.
    exit_ok = (int'(exit_slot) < NUM_SLOTS) && parking_capacity[exit_slot] &&
              !((state != ST_IDLE) && (exit_slot == park_number));
    if (exit_req) begin
      if (exit_ok) cap_clr[exit_slot] = 1'b1;
      else         exit_err_n = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (entry_req) begin
          if (free_found) begin
            cap_set[free_idx] = 1'b1;
            park_number_n     = free_idx;
            park_valid_n      = 1'b1;
            state_n           = ST_GRANT;
          end else begin
            entry_reject_n = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        gate_open_n = 1'b1;
        timer_n     = '0;
        state_n     = ST_OPEN;
      end
      ST_OPEN: begin
        if (car_passed) begin
          gate_open_n  = 1'b0;
          park_valid_n = 1'b0;
          timer_n      = '0;
          state_n      = ST_IDLE;
        end else if (timer == TIMER_W'(GATE_TIMEOUT - 1)) begin
          cap_clr[park_number] = 1'b1;
          gate_open_n          = 1'b0;
          park_valid_n         = 1'b0;
          timer_n              = '0;
          state_n              = ST_IDLE;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      default: begin
        gate_open_n  = 1'b0;
        park_valid_n = 1'b0;
        timer_n      = '0;
        state_n      = ST_IDLE;
      end
    endcase

    cap_n  = (parking_capacity | cap_set) & ~cap_clr;
    free_n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_n = free_n + {{SLOT_W{1'b0}}, ~cap_n[i]};
    end
  end

endmodule

// File: tb/tb_parking_controller.sv
// Directed bench for parking_controller: entry, fill, reject, timeout, exit errors and reset.
module tb_parking_controller;

  logic       clk = 1'b0;
  logic       reset, entry_req, car_passed, exit_req;
  logic [2:0] exit_slot;
  logic [7:0] parking_capacity;
  logic [2:0] park_number;
  logic       park_valid, gate_open, full, entry_reject, exit_err;
  logic [3:0] free_count;

  int errors = 0;
  int checks = 0;

  parking_controller dut (
    .clk              (clk),
    .reset            (reset),
    .entry_req        (entry_req),
    .car_passed       (car_passed),
    .exit_req         (exit_req),
    .exit_slot        (exit_slot),
    .parking_capacity (parking_capacity),
    .park_number      (park_number),
    .park_valid       (park_valid),
    .gate_open        (gate_open),
    .full             (full),
    .free_count       (free_count),
    .entry_reject     (entry_reject),
    .exit_err         (exit_err)
  );

  always #5 clk = ~clk;

  // Outputs are inspected 1 time unit after the edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park_car();
    entry_req = 1'b1; step();
    entry_req = 1'b0; step();
    car_passed = 1'b1; step();
    car_passed = 1'b0;
  endtask

  task automatic do_exit(input logic [2:0] slot);
    exit_req = 1'b1; exit_slot = slot; step();
    exit_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; entry_req = 1'b0; car_passed = 1'b0; exit_req = 1'b0; exit_slot = '0;
    step(); step();
    reset = 1'b0;
    checks++; if (parking_capacity !== 8'h00) begin errors++; $display("FAIL reset_cap: got %h expected 00", parking_capacity); end
    checks++; if (park_number !== 3'd0) begin errors++; $display("FAIL reset_park_number: got %0d expected 0", park_number); end
    checks++; if ({park_valid, gate_open, full, entry_reject, exit_err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {park_valid, gate_open, full, entry_reject, exit_err}); end
    checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_free: got %0d expected 8", free_count); end
  endtask

  task automatic test_basic_entry();
    entry_req = 1'b1; step();
    entry_req = 1'b0;
    checks++; if (park_number !== 3'd0 || park_valid !== 1'b1) begin errors++; $display("FAIL grant_slot: got num=%0d valid=%b expected num=0 valid=1", park_number, park_valid); end
    checks++; if (parking_capacity !== 8'h01 || gate_open !== 1'b0) begin errors++; $display("FAIL grant_cap: got cap=%h gate=%b expected cap=01 gate=0", parking_capacity, gate_open); end
    step();
    checks++; if (gate_open !== 1'b1 || park_valid !== 1'b1) begin errors++; $display("FAIL open_gate: got gate=%b valid=%b expected 1 1", gate_open, park_valid); end
    car_passed = 1'b1; step();
    car_passed = 1'b0;
    checks++; if (gate_open !== 1'b0 || park_valid !== 1'b0 || free_count !== 4'd7) begin errors++; $display("FAIL passed: got gate=%b valid=%b free=%0d expected 0 0 7", gate_open, park_valid, free_count); end
  endtask

  task automatic test_fill_and_reject();
    for (int i = 0; i < 7; i++) park_car();
    checks++; if (parking_capacity !== 8'hFF || full !== 1'b1) begin errors++; $display("FAIL fill: got cap=%h full=%b expected FF 1", parking_capacity, full); end
    do_exit(3'd3);
    checks++; if (parking_capacity !== 8'hF7 || full !== 1'b0 || free_count !== 4'd1) begin errors++; $display("FAIL exit3: got cap=%h full=%b free=%0d expected F7 0 1", parking_capacity, full, free_count); end
    entry_req = 1'b1; step();
    entry_req = 1'b0;
    checks++; if (park_number !== 3'd3 || parking_capacity !== 8'hFF || full !== 1'b1) begin errors++; $display("FAIL refill: got num=%0d cap=%h full=%b expected 3 FF 1", park_number, parking_capacity, full); end
    step(); car_passed = 1'b1; step(); car_passed = 1'b0;
    entry_req = 1'b1; step();
    checks++; if (entry_reject !== 1'b1 || parking_capacity !== 8'hFF) begin errors++; $display("FAIL reject1: got rej=%b cap=%h expected 1 FF", entry_reject, parking_capacity); end
    step();
    checks++; if (entry_reject !== 1'b1 || park_valid !== 1'b0) begin errors++; $display("FAIL reject2: got rej=%b valid=%b expected 1 0", entry_reject, park_valid); end
    entry_req = 1'b0; step();
    checks++; if (entry_reject !== 1'b0) begin errors++; $display("FAIL reject_clear: got %b expected 0", entry_reject); end
  endtask

  task automatic test_exit_with_entry_full();
    exit_req = 1'b1; exit_slot = 3'd5; entry_req = 1'b1; step();
    exit_req = 1'b0;
    checks++; if (entry_reject !== 1'b1 || parking_capacity !== 8'hDF || full !== 1'b0) begin errors++; $display("FAIL exit_entry: got rej=%b cap=%h full=%b expected 1 DF 0", entry_reject, parking_capacity, full); end
    step();
    entry_req = 1'b0;
    checks++; if (park_number !== 3'd5 || parking_capacity !== 8'hFF || park_valid !== 1'b1) begin errors++; $display("FAIL retry: got num=%0d cap=%h valid=%b expected 5 FF 1", park_number, parking_capacity, park_valid); end
    step(); car_passed = 1'b1; step(); car_passed = 1'b0;
  endtask

  task automatic test_timeout();
    do_exit(3'd6);
    entry_req = 1'b1; step();
    entry_req = 1'b0;
    checks++; if (park_number !== 3'd6 || parking_capacity !== 8'hFF) begin errors++; $display("FAIL to_grant: got num=%0d cap=%h expected 6 FF", park_number, parking_capacity); end
    step();
    for (int i = 0; i < 15; i++) step();
    checks++; if (gate_open !== 1'b1 || parking_capacity !== 8'hFF) begin errors++; $display("FAIL to_hold: got gate=%b cap=%h expected 1 FF", gate_open, parking_capacity); end
    step();
    checks++; if (gate_open !== 1'b0 || parking_capacity !== 8'hBF || park_valid !== 1'b0) begin errors++; $display("FAIL to_release: got gate=%b cap=%h valid=%b expected 0 BF 0", gate_open, parking_capacity, park_valid); end
    // Second round: car_passed arrives on the timeout cycle and keeps the slot.
    entry_req = 1'b1; step();
    entry_req = 1'b0; step();
    for (int i = 0; i < 15; i++) step();
    car_passed = 1'b1; step();
    car_passed = 1'b0;
    checks++; if (gate_open !== 1'b0 || parking_capacity !== 8'hFF) begin errors++; $display("FAIL to_race: got gate=%b cap=%h expected 0 FF", gate_open, parking_capacity); end
    do_exit(3'd6);
  endtask

  task automatic test_exit_err();
    do_exit(3'd2);
    checks++; if (parking_capacity !== 8'hBB || exit_err !== 1'b0) begin errors++; $display("FAIL exit2: got cap=%h err=%b expected BB 0", parking_capacity, exit_err); end
    exit_req = 1'b1; exit_slot = 3'd2; step();
    exit_req = 1'b0;
    checks++; if (exit_err !== 1'b1 || parking_capacity !== 8'hBB) begin errors++; $display("FAIL exit_empty: got err=%b cap=%h expected 1 BB", exit_err, parking_capacity); end
    entry_req = 1'b1; step();
    entry_req = 1'b0;
    checks++; if (exit_err !== 1'b0 || park_number !== 3'd2 || parking_capacity !== 8'hBF) begin errors++; $display("FAIL err_pulse: got err=%b num=%0d cap=%h expected 0 2 BF", exit_err, park_number, parking_capacity); end
    step();
    do_exit(3'd2);
    checks++; if (exit_err !== 1'b1 || parking_capacity !== 8'hBF || gate_open !== 1'b1) begin errors++; $display("FAIL exit_reserved: got err=%b cap=%h gate=%b expected 1 BF 1", exit_err, parking_capacity, gate_open); end
    for (int i = 0; i < 14; i++) step();
    exit_req = 1'b1; exit_slot = 3'd0; step();
    exit_req = 1'b0;
    checks++; if (parking_capacity !== 8'hBA || gate_open !== 1'b0 || free_count !== 4'd3) begin errors++; $display("FAIL exit_timeout: got cap=%h gate=%b free=%0d expected BA 0 3", parking_capacity, gate_open, free_count); end
  endtask

  task automatic test_back_to_back();
    entry_req = 1'b1; step();
    checks++; if (park_number !== 3'd0 || parking_capacity !== 8'hBB) begin errors++; $display("FAIL b2b_first: got num=%0d cap=%h expected 0 BB", park_number, parking_capacity); end
    step(); car_passed = 1'b1; step(); car_passed = 1'b0;
    checks++; if (park_valid !== 1'b0 || gate_open !== 1'b0) begin errors++; $display("FAIL b2b_idle: got valid=%b gate=%b expected 0 0", park_valid, gate_open); end
    step();
    entry_req = 1'b0;
    checks++; if (park_number !== 3'd2 || park_valid !== 1'b1 || parking_capacity !== 8'hBF) begin errors++; $display("FAIL b2b_second: got num=%0d valid=%b cap=%h expected 2 1 BF", park_number, park_valid, parking_capacity); end
    step();
  endtask

  task automatic test_reset_mid_open();
    step(); step();
    checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL pre_reset_gate: got %b expected 1", gate_open); end
    reset = 1'b1; car_passed = 1'b1; step();
    reset = 1'b0; car_passed = 1'b0;
    checks++; if (parking_capacity !== 8'h00 || gate_open !== 1'b0 || park_valid !== 1'b0 || park_number !== 3'd0) begin errors++; $display("FAIL mid_reset: got cap=%h gate=%b valid=%b num=%0d expected 00 0 0 0", parking_capacity, gate_open, park_valid, park_number); end
    checks++; if (free_count !== 4'd8 || full !== 1'b0) begin errors++; $display("FAIL mid_reset_free: got free=%0d full=%b expected 8 0", free_count, full); end
    step();
    checks++; if (gate_open !== 1'b0 || park_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got gate=%b valid=%b expected 0 0", gate_open, park_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_entry();
    test_fill_and_reject();
    test_exit_with_entry_full();
    test_timeout();
    test_exit_err();
    test_back_to_back();
    test_reset_mid_open();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
